io_rail_seq: RTL

- Sequenced controller for the segmented IO supply rails of the pad ring.
- Works as the switchable counterpart of the permanent rail-short cells. It enables the rail switch segments one at a time, then confirms rail power-good.
- It reports "ready" to the chip power manager over a level req/ack handshake. Power-down runs in reverse segment order.
- Sits in the always-on domain, between the power-management FSM and the IO ring switch cells.

---
 rtl/io_rail_pkg.sv | 23 ++
 rtl/io_rail_pg_filt.sv | 61 ++++++
 rtl/io_rail_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/io_rail_pkg.sv
// Shared types and helpers for the IO rail sequencer.
package io_rail_pkg;

  // Depth of the pg_i synchronizer chain.
  localparam int IO_RAIL_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_UP      = 3'd1,
    ST_WAIT_PG = 3'd2,
    ST_ON      = 3'd3,
    ST_DOWN    = 3'd4,
    ST_FAULT   = 3'd5
  } io_rail_state_e;

  // Width of the shared step/timeout counter: enough to hold the larger limit.
  function automatic int io_rail_cnt_width(input int settle_cyc, input int to_cyc);
    int max_cyc;
    max_cyc = (settle_cyc > to_cyc) ? settle_cyc : to_cyc;
    return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/io_rail_pg_filt.sv
// Power-good conditioning: 2-FF synchronizer followed by a saturating
// run-length filter. pg_good rises after PG_FILT consecutive synchronized
// high samples. Once established it is only withdrawn after two consecutive
// synchronized low samples, so a single-sample dropout on a good rail does
// not trip the sequencer.
module io_rail_pg_filt
  import io_rail_pkg::*;
#(
  parameter int PG_FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pg_i,
  output logic pg_good
);

  localparam int             FW       = $clog2(PG_FILT + 1);
  localparam logic [FW-1:0]  FILT_MAX = FW'(PG_FILT);

  logic [IO_RAIL_SYNC_STAGES-1:0] sync;
  logic                           pg_s;
  logic [FW-1:0]                  cnt;
  logic                           low_q;
  logic                           hold;

  assign pg_s = sync[IO_RAIL_SYNC_STAGES-1];

  // Bring the analog detector output into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, which is what makes this a real two-stage chain.
      sync <= {sync[IO_RAIL_SYNC_STAGES-2:0], pg_i};
    end
  end

  // Count consecutive high samples; track established-good state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      low_q <= 1'b0;
      hold  <= 1'b0;
    end else begin
      low_q <= ~pg_s;
      if (!pg_s)
        cnt <= '0;
      else if (cnt != FILT_MAX)
        cnt <= cnt + FW'(1);

      if (cnt == FILT_MAX)
        hold <= 1'b1;
      else if (!pg_s && low_q)
        hold <= 1'b0;
    end
  end

  assign pg_good = hold | (cnt == FILT_MAX);

endmodule

// File: rtl/io_rail_seq.sv
// Sequenced controller for the segmented IO supply rails. Segments are
// enabled one at a time (bit 0 first), each step followed by a settle
// period; after the last segment settles, rail power-good is awaited and
// reported over a level req/ack handshake. Power-down peels segments off
// from the top. seg_en is kept as a thermometer code, so it also serves as
// the segment index: shift left to enable the next, shift right to drop
// the highest.
module io_rail_seq
  import io_rail_pkg::*;
#(
  parameter int N_SEG      = 4,
  parameter int SETTLE_CYC = 16,
  parameter int PG_FILT    = 4,
  parameter int TO_CYC     = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_req_i,
  input  logic             pg_i,
  output logic [N_SEG-1:0] seg_en_o,
  output logic             pwr_ack_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic [2:0]       state_o
);

  localparam int            CW          = io_rail_cnt_width(SETTLE_CYC, TO_CYC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TO_CYC - 1);

  io_rail_state_e   state;
  logic [N_SEG-1:0] seg_en;
  logic [CW-1:0]    cnt;
  logic             pg_good;

  io_rail_pg_filt #(
    .PG_FILT (PG_FILT)
  ) u_pg_filt (
    .clk     (clk),
    .rst     (rst),
    .pg_i    (pg_i),
    .pg_good (pg_good)
  );

  // Sequencer FSM: state, segment enables and the shared step/timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the switch enables sit on the async reset so the rails are cut
      // the moment reset asserts, without waiting for a clock edge.
      state  <= ST_OFF;
      seg_en <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (pwr_req_i) begin
            state  <= ST_UP;
            seg_en <= N_SEG'(1);
            cnt    <= '0;
          end
        end

        ST_UP: begin
          if (!pwr_req_i) begin
            state  <= ST_DOWN;
            seg_en <= seg_en >> 1;
            cnt    <= '0;
          end else if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (seg_en[N_SEG-1])
              state <= ST_WAIT_PG;
            else
              seg_en <= (seg_en << 1) | N_SEG'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_WAIT_PG: begin
          if (!pwr_req_i) begin
            state  <= ST_DOWN;
            seg_en <= seg_en >> 1;
            cnt    <= '0;
          end else if (pg_good) begin
            state <= ST_ON;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state  <= ST_FAULT;
            seg_en <= '0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_ON: begin
          if (!pwr_req_i) begin
            state  <= ST_DOWN;
            seg_en <= seg_en >> 1;
            cnt    <= '0;
          end else if (!pg_good) begin
            state  <= ST_FAULT;
            seg_en <= '0;
          end
        end

        ST_DOWN: begin
          if (seg_en == '0) begin
            state <= ST_OFF;
            cnt   <= '0;
          end else if (cnt == SETTLE_LAST) begin
            seg_en <= seg_en >> 1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_FAULT: begin
          seg_en <= '0;
          if (!pwr_req_i)
            state <= ST_OFF;
        end

        default: begin
          state  <= ST_OFF;
          seg_en <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign seg_en_o  = seg_en;
  assign pwr_ack_o = (state == ST_ON);
  assign busy_o    = (state == ST_UP) || (state == ST_WAIT_PG) || (state == ST_DOWN);
  assign fault_o   = (state == ST_FAULT);
  assign state_o   = state;

endmodule
